// File: rtl/slice_pkg.sv
// Shared types and width helpers for the slice job sequencer and its credit counter.
package slice_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   // Width able to hold 0..max_out inclusive.
   function automatic int cnt_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/credit_counter.sv
// Outstanding-beat counter with a credit limit; has_credit accounts for an increment
// already registered this cycle so the limit is never overrun.
module credit_counter
   import slice_pkg::*;
#(
   parameter int LIMIT = 8,
   parameter int W     = cnt_w(LIMIT)
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic has_credit,
   output logic empty,
   output logic underflow
);

   logic [W-1:0] count;
   logic [W:0]   pending;

   assign pending    = {1'b0, count} + (W+1)'(inc);
   assign has_credit = pending < (W+1)'(LIMIT);
   assign empty      = (count == '0);
   assign underflow  = dec && empty;

   // A decrement at zero is dropped (and flagged) rather than wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count <= '0;
      else      count <= count + W'(inc) - W'(dec && !empty);
   end

endmodule

// File: rtl/slice_ctrl.sv
// Job sequencer for one slice: load MAC_NB weights, stream BEATS image beats under credits,
// then drain results. Optional SLICE_CTRL_STATS_EN adds stall_cycles / job_cycles counters.
module slice_ctrl
   import slice_pkg::*;
#(
   parameter int MAC_NB          = 3,
   parameter int IMAGE_WIDTH     = 16,
   parameter int WEIGHT_WIDTH    = 8,
   parameter int BEAT_WIDTH      = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [BEAT_WIDTH-1:0]         beats,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   input  logic [WEIGHT_WIDTH-1:0]       wgt_in,
   input  logic                          wgt_in_valid,
   output logic                          wgt_in_ready,
   input  logic [IMAGE_WIDTH*MAC_NB-1:0] img_in,
   input  logic                          img_in_valid,
   output logic                          img_in_ready,
   output logic [WEIGHT_WIDTH-1:0]       weight,
   output logic [MAC_NB-1:0]             weight_valid,
   output logic [IMAGE_WIDTH*MAC_NB-1:0] image,
   output logic                          image_valid,
   input  logic                          result_valid
`ifdef SLICE_CTRL_STATS_EN
   ,
   output logic [31:0]                   stall_cycles,
   output logic [31:0]                   job_cycles
`endif
);

   localparam int IW = idx_w(MAC_NB);

   state_t                state, state_d;
   logic [IW-1:0]         idx;
   logic [BEAT_WIDTH-1:0] beat_cnt;
   logic                  has_credit, empty, underflow;
   logic                  wgt_acc, img_acc;

   credit_counter #(.LIMIT(MAX_OUTSTANDING)) u_credit (
      .clk       (clk),
      .rst       (rst),
      .inc       (image_valid),
      .dec       (result_valid),
      .has_credit(has_credit),
      .empty     (empty),
      .underflow (underflow)
   );

   assign wgt_acc = wgt_in_valid && wgt_in_ready;
   assign img_acc = img_in_valid && img_in_ready;
   assign busy    = (state != IDLE) && !done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d      = state;
      wgt_in_ready = 1'b0;
      img_in_ready = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE:  if (start) state_d = LOAD;
         LOAD: begin
            wgt_in_ready = 1'b1;
            if (wgt_in_valid && idx == IW'(MAC_NB - 1))
               state_d = (beat_cnt == '0) ? DRAIN : RUN;
         end
         RUN: begin
            img_in_ready = has_credit;
            if (img_in_valid && has_credit && beat_cnt == BEAT_WIDTH'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            // A beat strobed this cycle is not yet counted, so wait for it too.
            if (empty && !image_valid) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx          <= '0;
         beat_cnt     <= '0;
         weight       <= '0;
         weight_valid <= '0;
         image        <= '0;
         image_valid  <= 1'b0;
         err          <= 1'b0;
      end else begin
         weight_valid <= '0;
         image_valid  <= 1'b0;
         err          <= err | underflow;
         if (state == IDLE && start) begin
            beat_cnt <= beats;
            idx      <= '0;
         end
         if (wgt_acc) begin
            weight       <= wgt_in;
            weight_valid <= MAC_NB'(1) << idx;
            idx          <= idx + IW'(1);
         end
         if (img_acc) begin
            image       <= img_in;
            image_valid <= 1'b1;
            beat_cnt    <= beat_cnt - BEAT_WIDTH'(1);
         end
      end
   end

`ifdef SLICE_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         job_cycles   <= '0;
      end else if (state == IDLE && start) begin
         stall_cycles <= '0;
         job_cycles   <= '0;
      end else begin
         if (state == RUN && img_in_valid && !img_in_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (busy && job_cycles != '1) job_cycles <= job_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_slice_ctrl.sv
// Directed bench for slice_ctrl: one DUT with default credits, one with MAX_OUTSTANDING=2.
module tb_slice_ctrl;

   logic        clk, rst;
   // DUT A (MAX_OUTSTANDING=8)
   logic        start, busy, done, err;
   logic [15:0] beats;
   logic [7:0]  wgt_in, weight;
   logic        wgt_in_valid, wgt_in_ready;
   logic [47:0] img_in, image;
   logic        img_in_valid, img_in_ready, image_valid, result_valid;
   logic [2:0]  weight_valid;
   // DUT B (MAX_OUTSTANDING=2)
   logic        start_b, busy_b, done_b, err_b;
   logic [15:0] beats_b;
   logic [7:0]  wgt_in_b, weight_b;
   logic        wgt_in_valid_b, wgt_in_ready_b;
   logic [47:0] img_in_b, image_b;
   logic        img_in_valid_b, img_in_ready_b, image_valid_b, result_valid_b;
   logic [2:0]  weight_valid_b;
`ifdef SLICE_CTRL_STATS_EN
   logic [31:0] stall_cycles, job_cycles, stall_cycles_b, job_cycles_b;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   slice_ctrl #(.MAX_OUTSTANDING(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .beats(beats), .busy(busy), .done(done), .err(err),
      .wgt_in(wgt_in), .wgt_in_valid(wgt_in_valid), .wgt_in_ready(wgt_in_ready),
      .img_in(img_in), .img_in_valid(img_in_valid), .img_in_ready(img_in_ready),
      .weight(weight), .weight_valid(weight_valid), .image(image), .image_valid(image_valid),
      .result_valid(result_valid)
`ifdef SLICE_CTRL_STATS_EN
      , .stall_cycles(stall_cycles), .job_cycles(job_cycles)
`endif
   );

   slice_ctrl #(.MAX_OUTSTANDING(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .beats(beats_b), .busy(busy_b), .done(done_b),
      .err(err_b), .wgt_in(wgt_in_b), .wgt_in_valid(wgt_in_valid_b),
      .wgt_in_ready(wgt_in_ready_b), .img_in(img_in_b), .img_in_valid(img_in_valid_b),
      .img_in_ready(img_in_ready_b), .weight(weight_b), .weight_valid(weight_valid_b),
      .image(image_b), .image_valid(image_valid_b), .result_valid(result_valid_b)
`ifdef SLICE_CTRL_STATS_EN
      , .stall_cycles(stall_cycles_b), .job_cycles(job_cycles_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_wrdy"}, wgt_in_ready, 0);
      chk({tag, "_irdy"}, img_in_ready, 0);
      chk({tag, "_w"}, weight, 0);
      chk({tag, "_wv"}, weight_valid, 0);
      chk({tag, "_img"}, image, 0);
      chk({tag, "_iv"}, image_valid, 0);
   endtask

   initial begin
      int iss, ret, peak;
      bit done_seen;
      rst = 1'b0;
      {start, beats, wgt_in, wgt_in_valid, img_in, img_in_valid, result_valid} = '0;
      {start_b, beats_b, wgt_in_b, wgt_in_valid_b, img_in_b, img_in_valid_b, result_valid_b} = '0;

      // Reset state
      #2;
      @(negedge clk);
      chk_all_zero("rst");
      chk("rst_b_busy", busy_b, 0);
      chk("rst_b_irdy", img_in_ready_b, 0);
      nxt(); nxt();
      rst = 1'b1;
      nxt();

      // Job: 3 weights of 2, then 3 beats; start during RUN must be ignored.
      for (int c = 0; c < 15; c++) begin
         start        = (c == 0) || (c == 5);
         beats        = (c == 0) ? 16'd3 : 16'd7;
         wgt_in_valid = (c >= 1 && c <= 4);
         wgt_in       = (c == 4) ? 8'd9 : 8'd2;
         img_in_valid = (c >= 4 && c <= 6);
         img_in       = (c == 5) ? {16'd6, 16'd5, 16'd4} : {16'd3, 16'd2, 16'd1};
         result_valid = (c >= 9 && c <= 11);
         @(negedge clk);
         chk($sformatf("j1_busy_c%0d", c), busy, (c >= 1 && c <= 11));
         chk($sformatf("j1_done_c%0d", c), done, (c == 12));
         chk($sformatf("j1_wv_c%0d", c), weight_valid,
             (c == 2) ? 3'b001 : (c == 3) ? 3'b010 : (c == 4) ? 3'b100 : 3'b000);
         if (c >= 2) chk($sformatf("j1_w_c%0d", c), weight, 8'd2);
         if (c >= 1 && c <= 3) chk($sformatf("j1_wrdy_c%0d", c), wgt_in_ready, 1);
         if (c == 4) chk("j1_wrdy_run", wgt_in_ready, 0);
         chk($sformatf("j1_iv_c%0d", c), image_valid, (c >= 5 && c <= 7));
         if (c == 5 || c == 7) chk($sformatf("j1_img_c%0d", c), image, 48'h0003_0002_0001);
         if (c == 6) chk("j1_img_c6", image, 48'h0006_0005_0004);
         if (c >= 4 && c <= 6) chk($sformatf("j1_irdy_c%0d", c), img_in_ready, 1);
         if (c == 7) chk("j1_irdy_drain", img_in_ready, 0);
         chk($sformatf("j1_err_c%0d", c), err, 0);
         nxt();
      end
      {start, wgt_in_valid, img_in_valid, result_valid} = '0;

      // beats=0: weights only, done alongside the last weight strobe.
      for (int c = 0; c < 7; c++) begin
         start        = (c == 0);
         beats        = 16'd0;
         wgt_in_valid = (c >= 1 && c <= 3);
         wgt_in       = 8'(4 + c);
         img_in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("z_busy_c%0d", c), busy, (c >= 1 && c <= 3));
         chk($sformatf("z_done_c%0d", c), done, (c == 4));
         chk($sformatf("z_wv_c%0d", c), weight_valid,
             (c == 2) ? 3'b001 : (c == 3) ? 3'b010 : (c == 4) ? 3'b100 : 3'b000);
         if (c >= 2 && c <= 4) chk($sformatf("z_w_c%0d", c), weight, 8'(3 + c));
         chk($sformatf("z_iv_c%0d", c), image_valid, 0);
         chk($sformatf("z_irdy_c%0d", c), img_in_ready, 0);
         nxt();
      end
      {start, wgt_in_valid, img_in_valid} = '0;

      // Credit limit 2 with results withheld; beats=5.
      iss = 0; ret = 0; peak = 0; done_seen = 0;
      for (int c = 0; c < 80 && !done_seen; c++) begin
         start_b        = (c == 0);
         beats_b        = 16'd5;
         wgt_in_valid_b = (c >= 1 && c <= 3);
         wgt_in_b       = 8'd1;
         img_in_valid_b = (c >= 4);
         img_in_b       = 48'(c);
         result_valid_b = (c == 8) || (c >= 11 && iss > ret);
         @(negedge clk);
         if (image_valid_b)  iss++;
         if (result_valid_b) ret++;
         if (iss - ret > peak) peak = iss - ret;
         if (c == 4 || c == 5 || c == 9) chk($sformatf("cr_rdy_c%0d", c), img_in_ready_b, 1);
         if (c == 6 || c == 7 || c == 8 || c == 10)
            chk($sformatf("cr_rdy_c%0d", c), img_in_ready_b, 0);
`ifdef SLICE_CTRL_STATS_EN
         if (c == 9) begin
            chk("st_stall", stall_cycles_b, 32'd3);
            chk("st_job", job_cycles_b, 32'd8);
         end
`endif
         if (done_b) begin
            done_seen = 1;
            chk("cr_busy_at_done", busy_b, 0);
         end
         nxt();
      end
      {start_b, wgt_in_valid_b, img_in_valid_b, result_valid_b} = '0;
      chk("cr_done_seen", done_seen, 1);
      chk("cr_issued", iss, 5);
      chk("cr_returned", ret, 5);
      chk("cr_peak", peak, 2);
      chk("cr_err", err_b, 0);

      // Reset mid-RUN after 2 of 5 beats, then a late result sets sticky err.
      for (int c = 0; c < 13; c++) begin
         start        = (c == 0);
         beats        = 16'd5;
         wgt_in_valid = (c >= 1 && c <= 3);
         wgt_in       = 8'd3;
         img_in_valid = (c == 4 || c == 5);
         img_in       = {16'd9, 16'd8, 16'd7};
         result_valid = (c == 8);
         if (c == 6) rst = 1'b0;
         if (c == 7) rst = 1'b1;
         @(negedge clk);
         if (c == 5) chk("mr_iv_pre", image_valid, 1);
         if (c == 6) chk_all_zero("mr");
         if (c == 8) chk("mr_err_pre", err, 0);
         if (c >= 9) begin
            chk($sformatf("mr_err_c%0d", c), err, 1);
            chk($sformatf("mr_busy_c%0d", c), busy, 0);
         end
         nxt();
      end
      result_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("mr_err_cleared", err, 0);
      nxt();
      rst = 1'b1;
      nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/slice_ctrl.md
Name: slice_ctrl

Overview:
Job sequencer in front of one `slice` instance. For each job it loads MAC_NB kernel weights one at a time, using the slice's one-hot `weight_valid` write strobes. It then forwards exactly BEATS image beats under credit-based flow control, and drains until every issued beat has returned a `result_valid`. Weights are never rewritten while a product is in flight inside the slice.

Parameters:
MAC_NB, 3, number of MACs in the controlled slice (width of the weight_valid one-hot).
IMAGE_WIDTH, 16, bits per image lane.
WEIGHT_WIDTH, 8, bits per weight.
BEAT_WIDTH, 16, width of the job beat count.
MAX_OUTSTANDING, 8, maximum number of image beats issued without a returned result (must be ≥1).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
start  in  1  job request; sampled only in IDLE.
beats  in  BEAT_WIDTH  image beats in this job; latched on an accepted start.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a job completes.
err  out  1  sticky flag: result_valid arrived with zero outstanding; cleared only by reset.
wgt_in  in  WEIGHT_WIDTH  weight stream data.
wgt_in_valid  in  1  weight stream valid.
wgt_in_ready  out  1  weight stream ready.
img_in  in  IMAGE_WIDTH*MAC_NB  image stream data; lane k occupies bits [k*IMAGE_WIDTH +: IMAGE_WIDTH].
img_in_valid  in  1  image stream valid.
img_in_ready  out  1  image stream ready.
weight  out  WEIGHT_WIDTH  weight data to the slice.
weight_valid  out  MAC_NB  one-hot weight write strobe to the slice.
image  out  IMAGE_WIDTH*MAC_NB  image data to the slice.
image_valid  out  1  image valid to the slice.
result_valid  in  1  returned from the slice; one pulse per issued beat.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system): state=IDLE; all outputs 0, including busy, done, err, weight, weight_valid, image, image_valid and both readies.
- Handshakes: a transfer occurs when valid&&ready on a rising edge. All slice-side outputs are registered, so an accepted input appears at the slice exactly 1 cycle later. Strobes are held for 1 cycle only. weight and image hold their last value when not strobed.
- IDLE:
  - start=1 latches beats into the beat counter, clears weight index idx, and moves to LOAD.
  - start in any other state is ignored.
- LOAD:
  - wgt_in_ready=1.
  - On acceptance number idx: next cycle weight=wgt_in and weight_valid=(1<<idx); idx increments.
  - After MAC_NB acceptances, go to RUN, or to DRAIN if the latched beats==0.
- RUN:
  - img_in_ready = (outstanding < MAX_OUTSTANDING).
  - An accepted beat drives image/image_valid the next cycle and decrements the beat counter.
  - Acceptance of the last beat moves to DRAIN in the same edge.
- outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on each image_valid, −1 on each result_valid; both in the same cycle leaves it unchanged.
  - result_valid with outstanding==0 keeps it at 0 and sets err.
- DRAIN:
  - Both readies are 0.
  - When outstanding==0 and image_valid==0: assert done for 1 cycle and go to IDLE.
  - busy falls in the same cycle done is high.
- Boundaries:
  - wgt_in_valid in RUN or DRAIN is not accepted.
  - Reset mid-job aborts immediately and discards counts; results arriving later set err.
  - A new start is accepted no earlier than the cycle after done.

Optional Feature:
SLICE_CTRL_STATS_EN.
- Defined: adds two outputs, both cleared on accepted start and both saturating at all-ones:
  - stall_cycles [31:0]: counts RUN cycles with img_in_valid && !img_in_ready.
  - job_cycles [31:0]: counts busy cycles of the current job.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package slice_pkg holds:
  - enum state_t {IDLE, LOAD, RUN, DRAIN};
  - localparam function for the counter width.
- One natural sub-module, credit_counter. It holds the outstanding count with inc, dec and limit, and outputs has_credit, empty and underflow. It is reusable by later multi-slice controllers.

Test Plan:
- MAC_NB=3, weights 2,2,2 with back-to-back valid → weight_valid 001,010,100 on consecutive cycles; weight=2 each time.
- beats=3, image beats (1,2,3),(4,5,6),(1,2,3) continuous, slice result_valid 4 cycles after each beat → image_valid on 3 consecutive cycles; done exactly 1 cycle after the last result_valid.
- MAX_OUTSTANDING=2, results withheld → img_in_ready drops after 2 issues. Returning one result reopens ready the next cycle; total issued = 5 for beats=5.
- beats=0 → LOAD completes 3 weights, no image_valid, done 1 cycle after the third weight.
- Reset mid-RUN after 2 of 5 beats → all outputs 0 immediately. A late result_valid sets err=1, which stays 1 until the next reset.
- start pulsed during RUN → ignored, job continues unchanged. With SLICE_CTRL_STATS_EN, holding img_in_valid for 3 blocked cycles gives stall_cycles=3.
